weight_sram_loader: RTL
=======================

# weight_sram_loader

Upstream feeder for the weight router's SRAM. It accepts a byte-wide weight stream over a valid/ready handshake and packs consecutive bytes into SRAM-width words, little-endian by lane. Each completed word is written at an auto-incrementing address starting from a latched base. It drives the router's SRAM write port (`i_sram_write_en`, `i_write_addr`, `i_data_in`) directly and signals completion so the controller can start routing.

## Interface
- `DATA_WIDTH`, 8, width of one weight byte on the input stream
- `SRAM_DATA_WIDTH`, 64, width of one SRAM word; must be a multiple of `DATA_WIDTH`. Derived `LANES = SRAM_DATA_WIDTH/DATA_WIDTH`.
- `ADDR_WIDTH`, 8, SRAM address width

- `i_clk`  in  1  clock, all logic on rising edge
- `i_rst`  in  1  synchronous reset, active-high
- `i_start`  in  1  begin a transfer; honoured only in IDLE
- `i_base_addr`  in  ADDR_WIDTH  first word address; latched on accepted `i_start`
- `i_addr_limit`  in  ADDR_WIDTH  max words permitted; latched on accepted `i_start` (used only with the macro)
- `i_data`  in  DATA_WIDTH  stream byte
- `i_valid`  in  1  `i_data` valid
- `i_last`  in  1  qualifies the final byte of the transfer; sampled only on accept
- `o_ready`  out  1  loader can accept a byte
- `o_sram_write_en`  out  1  SRAM write strobe
- `o_sram_write_addr`  out  ADDR_WIDTH  SRAM write address
- `o_sram_data_in`  out  SRAM_DATA_WIDTH  packed word
- `o_busy`  out  1  transfer in progress
- `o_done`  out  1  one-cycle completion pulse
- `o_word_count`  out  ADDR_WIDTH+1  words written in the current or last transfer
- `o_error`  out  1  sticky overflow flag

## Operation
- States:
  - IDLE: `o_ready=0`. An `i_start` pulse moves to PACK, latches base and limit, and clears the lane index, word index, `o_word_count` and `o_error`.
  - PACK: `o_ready=1`.
  - FLUSH: one cycle; `o_ready=0`, final write in flight.
  - DONE: one cycle; `o_done=1`, returns to IDLE.
- Accept = `i_valid && o_ready`. The accepted byte goes into lane `lane_idx` at bits `[lane_idx*DATA_WIDTH +: DATA_WIDTH]`, and `lane_idx` increments.
- On accepting lane `LANES-1`, or any lane with `i_last=1`, the loader issues a write:
  - Address is `base + word_idx`, modulo 2^ADDR_WIDTH (wraps silently).
  - Data is the pack buffer with unfilled lanes forced to 0.
  - After the write, `word_idx++`, `o_word_count++`, and the pack buffer and `lane_idx` clear.
- Without `i_last`, PACK continues at full throughput. With `i_last`, the state goes to FLUSH.
- `i_start` outside IDLE is ignored. `i_valid` in IDLE, FLUSH or DONE is not accepted and is not stored.
- `i_rst` mid-transfer:
  - Returns to IDLE.
  - The partial word is discarded and no write is issued.
  - All outputs go to reset values.
- Reset values: `o_ready=0`, `o_sram_write_en=0`, `o_sram_write_addr=0`, `o_sram_data_in=0`, `o_busy=0`, `o_done=0`, `o_word_count=0`, `o_error=0`.

## Timing
- All outputs are registered.
- A write caused by an accept at edge E has `o_sram_write_en` high from E to E+1. It is low otherwise, with addr/data returning to 0.
- Throughput is 1 byte/cycle in PACK, and writes overlap continued acceptance.
- For the last byte accepted at edge E:
  - The write strobe is high in cycle E..E+1 (FLUSH).
  - `o_done` is high in cycle E+1..E+2 (DONE).
  - `o_busy` drops at E+2.
  - `o_ready` is low from E onward.
- `o_busy` is high from the edge accepting `i_start` through the DONE cycle.
- Earliest first accept is one cycle after `i_start` is sampled.
- `o_word_count` and `o_error` hold after DONE until the next accepted `i_start`.

## Configuration
- `WEIGHT_LOADER_LIMIT_CHECK_EN` defined:
  - A write whose `word_idx >= i_addr_limit` (latched) is suppressed: no strobe, and `o_word_count` does not increment.
  - `o_error` sets and stays set.
  - Bytes are still accepted so the stream drains, and the transfer still ends with FLUSH/DONE on `i_last`.
- Macro undefined: no limit comparison, `i_addr_limit` is unused, and `o_error` is constant 0.

## Test plan
- Full words: base 0x10, bytes 0x00..0x0F continuous, `i_last` on 0x0F. Expect writes at 0x10 = 0x0706050403020100 and 0x11 = 0x0F0E0D0C0B0A0908, `o_done` one cycle after the second strobe, `o_word_count=2`.
- Partial word: base 0x20, bytes 0xAA, 0xBB, 0xCC with last. Expect a single write at 0x20 = 0x0000000000CCBBAA, `o_word_count=1`.
- Bubbles: 8 bytes 0x11..0x88 with `i_valid` toggling every cycle. Expect one write 0x8877665544332211, and no strobe before the 8th accept.
- Wrap: base 0xFF, 16 bytes. Expect writes at 0xFF then 0x00.
- Reset mid-transfer: 5 bytes accepted, then `i_rst` for 1 cycle. Expect no strobe, all outputs 0, IDLE. A new `i_start` works normally.
- Limit (macro on): `i_addr_limit=1`, 16 bytes. Expect one write at base only, `o_error=1`, `o_word_count=1`, `o_done` still pulses.

Source files
------------

// File: rtl/weight_sram_loader_if.sv
// Byte-stream in, SRAM write port and status out, for weight_sram_loader.
// master = stream source / controller side, slave = the loader.
interface weight_sram_loader_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8
);
  logic                       i_start;
  logic [ADDR_WIDTH-1:0]      i_base_addr;
  logic [ADDR_WIDTH-1:0]      i_addr_limit;
  logic [DATA_WIDTH-1:0]      i_data;
  logic                       i_valid;
  logic                       i_last;
  logic                       o_ready;
  logic                       o_sram_write_en;
  logic [ADDR_WIDTH-1:0]      o_sram_write_addr;
  logic [SRAM_DATA_WIDTH-1:0] o_sram_data_in;
  logic                       o_busy;
  logic                       o_done;
  logic [ADDR_WIDTH:0]        o_word_count;
  logic                       o_error;

  modport master (
    output i_start, i_base_addr, i_addr_limit,
    output i_data, i_valid, i_last,
    input  o_ready, o_sram_write_en,
    input  o_sram_write_addr, o_sram_data_in,
    input  o_busy, o_done, o_word_count, o_error
  );

  modport slave (
    input  i_start, i_base_addr, i_addr_limit,
    input  i_data, i_valid, i_last,
    output o_ready, o_sram_write_en,
    output o_sram_write_addr, o_sram_data_in,
    output o_busy, o_done, o_word_count, o_error
  );
endinterface

// File: rtl/weight_sram_loader.sv
// Packs a byte stream into SRAM words written at base + word index.
// WEIGHT_LOADER_LIMIT_CHECK_EN: suppress writes past the latched limit.
module weight_sram_loader #(
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  weight_sram_loader_if.slave bus
);
  localparam int LANES = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PACK  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                 state;
  logic [LW-1:0]              lane_idx;
  logic [SRAM_DATA_WIDTH-1:0] pack_buf;
  logic [SRAM_DATA_WIDTH-1:0] pack_nxt;
  logic [ADDR_WIDTH-1:0]      base;
  logic [ADDR_WIDTH:0]        word_idx;
  logic [ADDR_WIDTH:0]        word_count;
  logic                       ready;
  logic                       we;
  logic [ADDR_WIDTH-1:0]      waddr;
  logic [SRAM_DATA_WIDTH-1:0] wdata;
  logic                       busy;
  logic                       done;
  logic                       accept;
  logic                       word_end;
  logic                       allow;

  // pack_buf only ever holds filled lanes, so unfilled lanes read as 0
  always_comb begin
    pack_nxt = pack_buf;
    pack_nxt[lane_idx*DATA_WIDTH +: DATA_WIDTH] = bus.i_data;
  end

  assign accept = bus.i_valid && ready;
  assign word_end = accept &&
    (lane_idx == LW'(LANES-1) || bus.i_last);

`ifdef WEIGHT_LOADER_LIMIT_CHECK_EN
  logic [ADDR_WIDTH-1:0] limit;
  logic                  error;

  assign allow = word_idx < {1'b0, limit};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      limit <= '0;
      error <= 1'b0;
    end else if (state == IDLE && bus.i_start) begin
      limit <= bus.i_addr_limit;
      error <= 1'b0;
    end else if (word_end && !allow) begin
      error <= 1'b1;
    end
  end

  assign bus.o_error = error;
`else
  logic unused_limit;
  assign unused_limit = ^bus.i_addr_limit;
  assign allow = 1'b1;
  assign bus.o_error = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      lane_idx   <= '0;
      pack_buf   <= '0;
      base       <= '0;
      word_idx   <= '0;
      word_count <= '0;
      ready      <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          state      <= PACK;
          base       <= bus.i_base_addr;
          lane_idx   <= '0;
          pack_buf   <= '0;
          word_idx   <= '0;
          word_count <= '0;
          ready      <= 1'b1;
          busy       <= 1'b1;
        end
        PACK: if (accept) begin
          if (word_end) begin
            we       <= allow;
            pack_buf <= '0;
            lane_idx <= '0;
            word_idx <= word_idx + 1'b1;
            if (allow) begin
              waddr <= base + word_idx[ADDR_WIDTH-1:0];
              wdata <= pack_nxt;
              word_count <= word_count + 1'b1;
            end
          end else begin
            pack_buf <= pack_nxt;
            lane_idx <= lane_idx + 1'b1;
          end
          if (bus.i_last) begin
            state <= FLUSH;
            ready <= 1'b0;
          end
        end
        FLUSH: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready           = ready;
  assign bus.o_sram_write_en   = we;
  assign bus.o_sram_write_addr = waddr;
  assign bus.o_sram_data_in    = wdata;
  assign bus.o_busy            = busy;
  assign bus.o_done            = done;
  assign bus.o_word_count      = word_count;
endmodule
